// File: rtl/cache_pkg.sv
// Shared types and helpers for the memory transfer unit.
//
// Contents:
//   mtu_state_e        - transfer FSM states
//   calc_beats()       - beats per line for a given bus width and line size
//   calc_offset_bits() - byte-offset bits inside a line
//   line_t             - cache line container for the default 32-byte line
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_BEAT,
    WB_ACK,
    RD_REQ,
    RD_WAIT,
    FILL_DONE,
    GAP
  } mtu_state_e;

  localparam int DEFAULT_BLOCK_SIZE = 32;

  typedef logic [8*DEFAULT_BLOCK_SIZE-1:0] line_t;

  function automatic int unsigned calc_beats(input int unsigned data_width,
                                             input int unsigned block_size);
    return (8 * block_size) / data_width;
  endfunction

  function automatic int unsigned calc_offset_bits(input int unsigned block_size);
    return $clog2(block_size);
  endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// Line buffer that is loaded whole or written one beat at a time, and read
// one beat at a time.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset (buffer clears to 0)
//   load_en      - capture load_line in full (takes priority over beat write)
//   load_line    - full line to capture
//   beat_wr_en   - write beat_wdata into slice beat_idx
//   beat_idx     - slice index; slice 0 holds the line LSBs
//   beat_wdata   - beat to store
//   line_next    - value the buffer takes at the next edge (includes this
//                  cycle's write), so a caller can latch the completed line
//   beat_rdata   - current contents of slice beat_idx
module line_beat_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 32,
  parameter int BEAT_W     = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_en,
  input  logic [8*BLOCK_SIZE-1:0] load_line,
  input  logic                    beat_wr_en,
  input  logic [BEAT_W-1:0]       beat_idx,
  input  logic [DATA_WIDTH-1:0]   beat_wdata,
  output logic [8*BLOCK_SIZE-1:0] line_next,
  output logic [DATA_WIDTH-1:0]   beat_rdata
);

  logic [8*BLOCK_SIZE-1:0] line_q;
  logic [8*BLOCK_SIZE-1:0] line_d;

  always_comb begin
    line_d = line_q;
    if (load_en) begin
      line_d = load_line;
    end else if (beat_wr_en) begin
      line_d[32'(beat_idx)*DATA_WIDTH +: DATA_WIDTH] = beat_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign line_next  = line_d;
  assign beat_rdata = line_q[32'(beat_idx)*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/memory_transfer_unit.sv
// Memory transfer unit: converts whole-line fetch and write-back requests
// from the cache controller into DATA_WIDTH-wide beats on the memory bus.
//
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   fetchReq, fetch_address         - line fill request (held until fetchValid)
//   fetch_data, fetchValid          - assembled line, one-cycle completion pulse
//   writeBackReq, writeBackAddress,
//   writeBackData                   - dirty-line write-back request
//   writeBackAck                    - one-cycle pulse once every beat is accepted
//   busy                            - high whenever the FSM is not idle
//   memReq, memWrite, memAddress,
//   memWData, memReady              - beat request channel
//   memRData, memRValid             - read return channel
//   protocolError                   - sticky flag: read data arrived unexpectedly
module memory_transfer_unit
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_SIZE    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetchReq,
  input  logic [ADDRESS_WIDTH-1:0] fetch_address,
  output logic [8*BLOCK_SIZE-1:0]  fetch_data,
  output logic                     fetchValid,
  input  logic                     writeBackReq,
  input  logic [ADDRESS_WIDTH-1:0] writeBackAddress,
  input  logic [8*BLOCK_SIZE-1:0]  writeBackData,
  output logic                     writeBackAck,
  output logic                     busy,
  output logic                     memReq,
  output logic                     memWrite,
  output logic [ADDRESS_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0]    memWData,
  input  logic                     memReady,
  input  logic [DATA_WIDTH-1:0]    memRData,
  input  logic                     memRValid,
  output logic                     protocolError
);

  localparam int BEATS       = int'(calc_beats(DATA_WIDTH, BLOCK_SIZE));
  localparam int OFFSET_BITS = int'(calc_offset_bits(BLOCK_SIZE));
  localparam int BEAT_BYTES  = DATA_WIDTH / 8;
  localparam int BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK =
    {{(ADDRESS_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  mtu_state_e                state_q, state_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [ADDRESS_WIDTH-1:0]  base_q, base_d;
  logic [8*BLOCK_SIZE-1:0]   fetch_data_q, fetch_data_d;
  logic                      protocol_error_q, protocol_error_d;

  logic                      buf_load_en;
  logic                      buf_beat_wr_en;
  logic [8*BLOCK_SIZE-1:0]   buf_line_next;
  logic [DATA_WIDTH-1:0]     buf_beat_rdata;
  logic [ADDRESS_WIDTH-1:0]  beat_addr;

  // One buffer serves both directions: it holds the dirty line during a
  // write-back and accumulates returned beats during a fill. fetch_data is a
  // separate register so the last completed fill survives later transfers.
  line_beat_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE),
    .BEAT_W     (BEAT_W)
  ) u_line_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (buf_load_en),
    .load_line  (writeBackData),
    .beat_wr_en (buf_beat_wr_en),
    .beat_idx   (beat_q),
    .beat_wdata (memRData),
    .line_next  (buf_line_next),
    .beat_rdata (buf_beat_rdata)
  );

  // Address wraps modulo 2^ADDRESS_WIDTH by construction of the add width.
  assign beat_addr = base_q + (ADDRESS_WIDTH'(beat_q) * ADDRESS_WIDTH'(BEAT_BYTES));

  always_comb begin
    state_d          = state_q;
    beat_d           = beat_q;
    base_d           = base_q;
    fetch_data_d     = fetch_data_q;
    // Read data is only legal while a read is outstanding.
    protocol_error_d = protocol_error_q | (memRValid && (state_q != RD_WAIT));
    buf_load_en      = 1'b0;
    buf_beat_wr_en   = 1'b0;
    memReq           = 1'b0;
    memWrite         = 1'b0;
    memAddress       = '0;
    memWData         = '0;
    writeBackAck     = 1'b0;
    fetchValid       = 1'b0;
    busy             = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        // Write-back wins so a dirty victim leaves before its fill arrives.
        if (writeBackReq) begin
          base_d      = writeBackAddress & ALIGN_MASK;
          beat_d      = '0;
          buf_load_en = 1'b1;
          state_d     = WR_BEAT;
        end else if (fetchReq) begin
          base_d  = fetch_address & ALIGN_MASK;
          beat_d  = '0;
          state_d = RD_REQ;
        end
      end

      WR_BEAT: begin
        memReq     = 1'b1;
        memWrite   = 1'b1;
        memAddress = beat_addr;
        memWData   = buf_beat_rdata;
        if (memReady) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = WB_ACK;
          end
        end
      end

      WB_ACK: begin
        writeBackAck = 1'b1;
        state_d      = GAP;
      end

      RD_REQ: begin
        memReq     = 1'b1;
        memAddress = beat_addr;
        if (memReady) begin
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (memRValid) begin
          buf_beat_wr_en = 1'b1;
          beat_d         = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            // Latch the line including this final beat so fetch_data is
            // complete in the same cycle fetchValid is raised.
            fetch_data_d = buf_line_next;
            state_d      = FILL_DONE;
          end else begin
            state_d = RD_REQ;
          end
        end
      end

      FILL_DONE: begin
        fetchValid = 1'b1;
        state_d    = GAP;
      end

      // Gives the controller a cycle to drop its request before IDLE looks again.
      GAP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      beat_q           <= '0;
      base_q           <= '0;
      fetch_data_q     <= '0;
      protocol_error_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      beat_q           <= beat_d;
      base_q           <= base_d;
      fetch_data_q     <= fetch_data_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  assign fetch_data    = fetch_data_q;
  assign protocolError = protocol_error_q;

endmodule

// File: tb/tb_memory_transfer_unit.sv
module tb_memory_transfer_unit;
  import cache_pkg::*;

  localparam int DW = 32;
  localparam int BS = 32;
  localparam int AW = 32;
  localparam int LW = 8 * BS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetchReq = 1'b0;
  logic [AW-1:0] fetch_address = '0;
  logic [LW-1:0] fetch_data;
  logic          fetchValid;
  logic          writeBackReq = 1'b0;
  logic [AW-1:0] writeBackAddress = '0;
  logic [LW-1:0] writeBackData = '0;
  logic          writeBackAck;
  logic          busy;
  logic          memReq;
  logic          memWrite;
  logic [AW-1:0] memAddress;
  logic [DW-1:0] memWData;
  logic          memReady = 1'b0;
  logic [DW-1:0] memRData = '0;
  logic          memRValid = 1'b0;
  logic          protocolError;

  int errors = 0;
  int checks = 0;

  // Read responder state: a read accepted in one cycle returns data the next.
  logic rd_pend = 1'b0;
  int   rd_cnt  = 0;

  always #5 clk = ~clk;

  memory_transfer_unit #(
    .DATA_WIDTH    (DW),
    .BLOCK_SIZE    (BS),
    .ADDRESS_WIDTH (AW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetchReq         (fetchReq),
    .fetch_address    (fetch_address),
    .fetch_data       (fetch_data),
    .fetchValid       (fetchValid),
    .writeBackReq     (writeBackReq),
    .writeBackAddress (writeBackAddress),
    .writeBackData    (writeBackData),
    .writeBackAck     (writeBackAck),
    .busy             (busy),
    .memReq           (memReq),
    .memWrite         (memWrite),
    .memAddress       (memAddress),
    .memWData         (memWData),
    .memReady         (memReady),
    .memRData         (memRData),
    .memRValid        (memRValid),
    .protocolError    (protocolError)
  );

  function automatic line_t make_line(input logic [31:0] base);
    line_t l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  // Advance one cycle, land on the falling edge, and play the memory side.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    memRValid = rd_pend;
    memRData  = rd_pend ? (32'h5500_0000 + 32'(rd_cnt)) : 32'h0;
    if (rd_pend) rd_cnt++;
    rd_pend = memReq && !memWrite && memReady;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, memReq, memWrite, writeBackAck, fetchValid, protocolError} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {busy, memReq, memWrite, writeBackAck, fetchValid, protocolError});
    end
    checks++;
    if (memAddress !== 32'h0 || memWData !== 32'h0 || fetch_data !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h fetch_data=%h required all zero",
               memAddress, memWData, fetch_data);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || memReq !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b memReq=%b required 0 0", busy, memReq);
    end
  endtask

  task automatic test_writeback();
    int ack_cyc = -1;
    int ack_cnt = 0;
    writeBackAddress = 32'h1000_0013;
    writeBackData    = make_line(32'hA000_0000);
    writeBackReq     = 1'b1;
    memReady         = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k <= 8) begin
        checks++;
        if (memReq !== 1'b1 || memWrite !== 1'b1 ||
            memAddress !== (32'h1000_0000 + 32'(4*(k-1))) ||
            memWData !== (32'hA000_0000 + 32'(k-1))) begin
          errors++;
          $display("FAIL wb_beat%0d: req=%b wr=%b addr=%h data=%h required 1 1 %h %h",
                   k-1, memReq, memWrite, memAddress, memWData,
                   32'h1000_0000 + 32'(4*(k-1)), 32'hA000_0000 + 32'(k-1));
        end
      end
      if (writeBackAck === 1'b1) begin
        if (ack_cyc < 0) ack_cyc = k;
        ack_cnt++;
        writeBackReq = 1'b0;
      end
      if (k == 10) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL wb_gap_busy: got %b required 1", busy);
        end
      end
      if (k == 11) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL wb_idle_busy: got %b required 0", busy);
        end
      end
    end
    checks++;
    if (ack_cyc != 9 || ack_cnt != 1) begin
      errors++;
      $display("FAIL wb_ack: cycle=%0d pulses=%0d required cycle 9 pulses 1", ack_cyc, ack_cnt);
    end
  endtask

  task automatic test_fetch();
    int    v_cyc = -1;
    line_t exp_line = make_line(32'h5500_0000);
    rd_cnt        = 0;
    rd_pend       = 1'b0;
    fetch_address = 32'h2000_0008;
    fetchReq      = 1'b1;
    memReady      = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (memReq === 1'b1) begin
        checks++;
        if (memWrite !== 1'b0 || memAddress !== (32'h2000_0000 + 32'(4*rd_cnt))) begin
          errors++;
          $display("FAIL rd_req%0d: wr=%b addr=%h required 0 %h",
                   rd_cnt, memWrite, memAddress, 32'h2000_0000 + 32'(4*rd_cnt));
        end
      end
      if (fetchValid === 1'b1 && v_cyc < 0) begin
        v_cyc    = k;
        fetchReq = 1'b0;
        checks++;
        if (fetch_data[31:0] !== 32'h5500_0000 || fetch_data[255:224] !== 32'h5500_0007 ||
            fetch_data !== exp_line) begin
          errors++;
          $display("FAIL fetch_line: got %h required %h", fetch_data, exp_line);
        end
      end
    end
    checks++;
    if (v_cyc != 17) begin
      errors++;
      $display("FAIL fetch_latency: got %0d required 17", v_cyc);
    end
  endtask

  task automatic test_stall();
    int ack_cyc = -1;
    checks++;
    if (fetch_data[31:0] !== 32'h5500_0000) begin
      errors++;
      $display("FAIL fetch_data_hold: got %h required 55000000", fetch_data[31:0]);
    end
    writeBackAddress = 32'h0000_0040;
    writeBackData    = make_line(32'hB000_0000);
    writeBackReq     = 1'b1;
    memReady         = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      memReady = !(k >= 3 && k <= 5);
      if (k >= 3 && k <= 6) begin
        checks++;
        if (memReq !== 1'b1 || memAddress !== 32'h0000_0048 || memWData !== 32'hB000_0002) begin
          errors++;
          $display("FAIL stall_hold_c%0d: req=%b addr=%h data=%h required 1 00000048 b0000002",
                   k, memReq, memAddress, memWData);
        end
      end
      if (writeBackAck === 1'b1 && ack_cyc < 0) begin
        ack_cyc      = k;
        writeBackReq = 1'b0;
      end
    end
    memReady = 1'b1;
    checks++;
    if (ack_cyc != 12) begin
      errors++;
      $display("FAIL stall_ack: cycle=%0d required 12", ack_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int    ack_cyc = -1;
    int    v_cyc = -1;
    int    nw = 0;
    int    nr = 0;
    logic  interleave = 1'b0;
    line_t exp_line = make_line(32'h5500_0000);
    rd_cnt           = 0;
    rd_pend          = 1'b0;
    writeBackAddress = 32'h4000_0000;
    writeBackData    = make_line(32'hC000_0000);
    fetch_address    = 32'h4000_0000;
    writeBackReq     = 1'b1;
    fetchReq         = 1'b1;
    memReady         = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (memReq === 1'b1 && memReady === 1'b1) begin
        if (memWrite === 1'b1) begin
          nw++;
          if (nr > 0) interleave = 1'b1;
        end else begin
          nr++;
        end
      end
      if (writeBackAck === 1'b1 && ack_cyc < 0) begin
        ack_cyc      = k;
        writeBackReq = 1'b0;
      end
      if (fetchValid === 1'b1 && v_cyc < 0) begin
        v_cyc    = k;
        fetchReq = 1'b0;
        checks++;
        if (fetch_data !== exp_line) begin
          errors++;
          $display("FAIL b2b_line: got %h required %h", fetch_data, exp_line);
        end
      end
    end
    checks++;
    if (nw != 8 || nr != 8 || interleave) begin
      errors++;
      $display("FAIL b2b_beats: writes=%0d reads=%0d interleave=%b required 8 8 0", nw, nr, interleave);
    end
    checks++;
    if (ack_cyc != 9 || v_cyc != 28) begin
      errors++;
      $display("FAIL b2b_order: ack=%0d valid=%0d required 9 28", ack_cyc, v_cyc);
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic  stray = 1'b0;
    int    v_cyc = -1;
    line_t exp_line = make_line(32'h5500_0000);
    rd_cnt        = 0;
    rd_pend       = 1'b0;
    fetch_address = 32'h2000_0000;
    fetchReq      = 1'b1;
    memReady      = 1'b1;
    for (int k = 1; k <= 9; k++) tick();
    checks++;
    if (memReq !== 1'b1 || memWrite !== 1'b0 || memAddress !== 32'h2000_0010) begin
      errors++;
      $display("FAIL mid_beat4: req=%b wr=%b addr=%h required 1 0 20000010", memReq, memWrite, memAddress);
    end
    #2;
    rst_n    = 1'b0;
    fetchReq = 1'b0;
    rd_pend  = 1'b0;
    rd_cnt   = 0;
    #1;
    checks++;
    if ({busy, memReq, fetchValid, writeBackAck} !== 4'b0 || memAddress !== 32'h0 ||
        fetch_data !== '0) begin
      errors++;
      $display("FAIL mid_async_reset: ctrl=%b addr=%h fetch_data=%h required zeros",
               {busy, memReq, fetchValid, writeBackAck}, memAddress, fetch_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (fetchValid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL mid_no_valid: stray activity after reset, required none");
    end
    fetch_address = 32'h3000_0004;
    fetchReq      = 1'b1;
    tick();
    checks++;
    if (memReq !== 1'b1 || memAddress !== 32'h3000_0000) begin
      errors++;
      $display("FAIL mid_restart_beat0: req=%b addr=%h required 1 30000000", memReq, memAddress);
    end
    for (int k = 2; k <= 24; k++) begin
      tick();
      if (fetchValid === 1'b1 && v_cyc < 0) begin
        v_cyc    = k;
        fetchReq = 1'b0;
      end
    end
    checks++;
    if (v_cyc != 17 || fetch_data !== exp_line) begin
      errors++;
      $display("FAIL mid_restart_fill: cycle=%0d line=%h required 17 %h", v_cyc, fetch_data, exp_line);
    end
  endtask

  task automatic test_protocol_error();
    int v_cyc = -1;
    checks++;
    if (protocolError !== 1'b0) begin
      errors++;
      $display("FAIL perr_clear: got %b required 0", protocolError);
    end
    memRValid = 1'b1;
    tick();
    tick();
    checks++;
    if (protocolError !== 1'b1) begin
      errors++;
      $display("FAIL perr_set: got %b required 1", protocolError);
    end
    rd_cnt        = 0;
    rd_pend       = 1'b0;
    fetch_address = 32'h0000_0100;
    fetchReq      = 1'b1;
    memReady      = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (fetchValid === 1'b1 && v_cyc < 0) begin
        v_cyc    = k;
        fetchReq = 1'b0;
      end
    end
    checks++;
    if (v_cyc != 17 || fetch_data !== make_line(32'h5500_0000)) begin
      errors++;
      $display("FAIL perr_fetch: cycle=%0d line=%h required 17 %h", v_cyc, fetch_data,
               make_line(32'h5500_0000));
    end
    checks++;
    if (protocolError !== 1'b1) begin
      errors++;
      $display("FAIL perr_sticky: got %b required 1", protocolError);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (protocolError !== 1'b0) begin
      errors++;
      $display("FAIL perr_reset: got %b required 0", protocolError);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_writeback();
    test_fetch();
    test_stall();
    test_back_to_back();
    test_reset_mid_fetch();
    test_protocol_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
